// File: rtl/minesweeper_pkg.sv
// +--------------------------------------------------------------------------+
// | minesweeper_pkg : shared game states, timer defaults and cursor helper   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package minesweeper_pkg;

  localparam logic [3:0] INIT = 4'b0001;
  localparam logic [3:0] PLAY = 4'b0010;
  localparam logic [3:0] WIN  = 4'b0100;
  localparam logic [3:0] LOSE = 4'b1000;

  localparam int DEF_TICK_CYCLES = 50_000_000;
  localparam int DEF_MAX_TIME    = 999;

  typedef enum logic [3:0] {
    S_INIT = INIT,
    S_PLAY = PLAY,
    S_WIN  = WIN,
    S_LOSE = LOSE
  } game_state_e;

  // Opposing pulses cancel; an edge either clamps or wraps to the far side.
  function automatic int step_pos(input int pos, input int size,
                                  input logic dec, input logic inc,
                                  input logic wrap);
    if (dec && !inc) begin
      if (pos == 0) return wrap ? size - 1 : 0;
      return pos - 1;
    end
    if (inc && !dec) begin
      if (pos == size - 1) return wrap ? 0 : pos;
      return pos + 1;
    end
    return pos;
  endfunction

endpackage

`default_nettype wire

// File: rtl/minesweeper_game_ctrl_timer.sv
// +--------------------------------------------------------------------------+
// | game_timer : cycle prescaler feeding a saturating elapsed-seconds count  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module game_timer
  import minesweeper_pkg::*;
#(
  parameter int TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int MAX_TIME    = DEF_MAX_TIME
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       run,
  output logic [9:0] time_sec
);

  localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_CYCLES - 1);
  localparam logic [9:0]       SEC_MAX = 10'(MAX_TIME);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [9:0]       sec_q, sec_d;

  always_comb begin
    pre_d = pre_q;
    sec_d = sec_q;
    if (clear) begin
      pre_d = '0;
      sec_d = '0;
    end else if (run) begin
      if (pre_q == PRE_MAX) begin
        pre_d = '0;
        if (sec_q != SEC_MAX) sec_d = sec_q + 10'd1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      sec_q <= '0;
    end else begin
      pre_q <= pre_d;
      sec_q <= sec_d;
    end
  end

  assign time_sec = sec_q;

endmodule

`default_nettype wire

// File: rtl/minesweeper_game_ctrl.sv
// +--------------------------------------------------------------------------+
// | minesweeper_game_ctrl : game FSM, cursor, cell/mine counters and timer   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module minesweeper_game_ctrl
  import minesweeper_pkg::*;
#(
  parameter int X_SIZE      = 16,
  parameter int Y_SIZE      = 16,
  parameter int X_BITS      = 4,
  parameter int Y_BITS      = 4,
  parameter int CNT_BITS    = X_BITS + Y_BITS + 1,
  parameter int WRAP        = 0,
  parameter int TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int MAX_TIME    = DEF_MAX_TIME
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mv_l,
  input  logic                       mv_r,
  input  logic                       mv_u,
  input  logic                       mv_d,
  input  logic                       act,
  input  logic                       flag_mode,
  input  logic                       restart,
  input  logic                       board_done,
  input  logic [CNT_BITS-1:0]        num_mines,
  input  logic [CNT_BITS-1:0]        num_non_mines,
  input  logic                       cell_opened,
  input  logic                       opened_is_mine,
  input  logic                       flag_toggled,
  input  logic                       flag_set,
  output logic [3:0]                 state,
  output logic [X_BITS-1:0]          x_pos,
  output logic [Y_BITS-1:0]          y_pos,
  output logic                       open_req,
  output logic                       flag_req,
  output logic                       board_restart,
  output logic [CNT_BITS-1:0]        cells_to_open,
  output logic signed [CNT_BITS:0]   mines_left,
  output logic [9:0]                 time_sec
);

  localparam logic                      WRAP_EN = (WRAP != 0);
  localparam logic [CNT_BITS-1:0]       ONE_C   = CNT_BITS'(1);
  localparam logic signed [CNT_BITS:0]  ONE_M   = (CNT_BITS+1)'(1);

  game_state_e               state_q, state_d;
  logic [X_BITS-1:0]         x_q, x_d;
  logic [Y_BITS-1:0]         y_q, y_d;
  logic                      open_req_q, open_req_d;
  logic                      flag_req_q, flag_req_d;
  logic                      brst_q, brst_d;
  logic [CNT_BITS-1:0]       cells_q, cells_d;
  logic signed [CNT_BITS:0]  mines_q, mines_d;
  logic                      timer_clear;
  logic                      timer_run;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    open_req_d  = 1'b0;
    flag_req_d  = 1'b0;
    brst_d      = 1'b0;
    cells_d     = cells_q;
    mines_d     = mines_q;
    timer_clear = 1'b0;

    if (restart) begin
      state_d = S_INIT;
      brst_d  = 1'b1;
    end else begin
      case (state_q)
        S_INIT: begin
          if (board_done) begin
            cells_d     = num_non_mines;
            mines_d     = $signed({1'b0, num_mines});
            timer_clear = 1'b1;
            state_d     = S_PLAY;
          end
        end
        S_PLAY: begin
          x_d = X_BITS'(step_pos(int'(x_q), X_SIZE, mv_l, mv_r, WRAP_EN));
          y_d = Y_BITS'(step_pos(int'(y_q), Y_SIZE, mv_u, mv_d, WRAP_EN));
          if (cell_opened) begin
            if (opened_is_mine) begin
              state_d = S_LOSE;
            end else if (cells_q != '0) begin
              cells_d = cells_q - ONE_C;
              if (cells_q == ONE_C) state_d = S_WIN;
            end
          end
          if (flag_toggled) begin
            mines_d = flag_set ? mines_q - ONE_M : mines_q + ONE_M;
          end
          // A game-ending open swallows the same-cycle action's request.
          if (act && state_d == S_PLAY) begin
            open_req_d = !flag_mode;
            flag_req_d = flag_mode;
          end
        end
        S_WIN, S_LOSE: begin
          x_d = X_BITS'(step_pos(int'(x_q), X_SIZE, mv_l, mv_r, WRAP_EN));
          y_d = Y_BITS'(step_pos(int'(y_q), Y_SIZE, mv_u, mv_d, WRAP_EN));
          if (act) begin
            state_d = S_INIT;
            brst_d  = 1'b1;
          end
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      x_q        <= '0;
      y_q        <= '0;
      open_req_q <= 1'b0;
      flag_req_q <= 1'b0;
      brst_q     <= 1'b0;
      cells_q    <= '0;
      mines_q    <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      open_req_q <= open_req_d;
      flag_req_q <= flag_req_d;
      brst_q     <= brst_d;
      cells_q    <= cells_d;
      mines_q    <= mines_d;
    end
  end

  assign timer_run = (state_q == S_PLAY);

  game_timer #(
    .TICK_CYCLES (TICK_CYCLES),
    .MAX_TIME    (MAX_TIME)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .run      (timer_run),
    .time_sec (time_sec)
  );

  assign state         = state_q;
  assign x_pos         = x_q;
  assign y_pos         = y_q;
  assign open_req      = open_req_q;
  assign flag_req      = flag_req_q;
  assign board_restart = brst_q;
  assign cells_to_open = cells_q;
  assign mines_left    = mines_q;

endmodule

`default_nettype wire

// File: tb/tb_minesweeper_game_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_minesweeper_game_ctrl : directed checks on clamped and wrapping DUTs  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_minesweeper_game_ctrl;

  localparam int CB = 9;
  localparam logic [3:0] C_INIT = 4'b0001;
  localparam logic [3:0] C_PLAY = 4'b0010;
  localparam logic [3:0] C_WIN  = 4'b0100;
  localparam logic [3:0] C_LOSE = 4'b1000;

  logic clk = 1'b0;
  logic reset;
  logic mv_l, mv_r, mv_u, mv_d, act, flag_mode, restart, board_done;
  logic [CB-1:0] num_mines, num_non_mines;
  logic cell_opened, opened_is_mine, flag_toggled, flag_set;

  logic [3:0] state0, state1;
  logic [3:0] x0, y0, x1, y1;
  logic open0, flag0, brst0, open1, flag1, brst1;
  logic [CB-1:0] cells0, cells1;
  logic signed [CB:0] mines0, mines1;
  logic [9:0] time0, time1;

  int n_checks = 0;
  int n_pass   = 0;
  logic signed [CB:0] exp_m;

  always #5 clk = ~clk;

  minesweeper_game_ctrl #(.WRAP(0), .TICK_CYCLES(4), .MAX_TIME(3)) dut0 (
    .clk(clk), .reset(reset), .mv_l(mv_l), .mv_r(mv_r), .mv_u(mv_u), .mv_d(mv_d),
    .act(act), .flag_mode(flag_mode), .restart(restart), .board_done(board_done),
    .num_mines(num_mines), .num_non_mines(num_non_mines), .cell_opened(cell_opened),
    .opened_is_mine(opened_is_mine), .flag_toggled(flag_toggled), .flag_set(flag_set),
    .state(state0), .x_pos(x0), .y_pos(y0), .open_req(open0), .flag_req(flag0),
    .board_restart(brst0), .cells_to_open(cells0), .mines_left(mines0), .time_sec(time0));

  minesweeper_game_ctrl #(.WRAP(1), .TICK_CYCLES(4), .MAX_TIME(3)) dut1 (
    .clk(clk), .reset(reset), .mv_l(mv_l), .mv_r(mv_r), .mv_u(mv_u), .mv_d(mv_d),
    .act(act), .flag_mode(flag_mode), .restart(restart), .board_done(board_done),
    .num_mines(num_mines), .num_non_mines(num_non_mines), .cell_opened(cell_opened),
    .opened_is_mine(opened_is_mine), .flag_toggled(flag_toggled), .flag_set(flag_set),
    .state(state1), .x_pos(x1), .y_pos(y1), .open_req(open1), .flag_req(flag1),
    .board_restart(brst1), .cells_to_open(cells1), .mines_left(mines1), .time_sec(time1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mv_l = 0; mv_r = 0; mv_u = 0; mv_d = 0; act = 0; flag_mode = 0;
    restart = 0; board_done = 0; num_mines = '0; num_non_mines = '0;
    cell_opened = 0; opened_is_mine = 0; flag_toggled = 0; flag_set = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    #3;
    reset = 0;
    tick();
  endtask

  task automatic start_game(input int nm, input int nnm);
    num_mines = CB'(nm);
    num_non_mines = CB'(nnm);
    board_done = 1;
    tick();
    board_done = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    #12;
    n_checks++; if (state0 !== C_INIT) $display("FAIL reset_state: got %b want %b", state0, C_INIT); else n_pass++;
    n_checks++; if ({x0, y0} !== 8'd0) $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", x0, y0); else n_pass++;
    n_checks++; if (cells0 !== '0 || mines0 !== '0 || time0 !== '0)
      $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", cells0, mines0, time0); else n_pass++;
    n_checks++; if ({open0, flag0, brst0} !== 3'b000)
      $display("FAIL reset_reqs: got %b want 000", {open0, flag0, brst0}); else n_pass++;
    reset = 0;
    tick();
  endtask

  task automatic test_board_done();
    start_game(56, 200);
    n_checks++; if (state0 !== C_PLAY) $display("FAIL bd_state: got %b want %b", state0, C_PLAY); else n_pass++;
    n_checks++; if (cells0 !== 9'd200) $display("FAIL bd_cells: got %0d want 200", cells0); else n_pass++;
    n_checks++; if (mines0 !== 10'sd56) $display("FAIL bd_mines: got %0d want 56", mines0); else n_pass++;
    n_checks++; if (time0 !== 10'd0) $display("FAIL bd_time: got %0d want 0", time0); else n_pass++;
    start_game(5, 5);
    n_checks++; if (cells0 !== 9'd200 || mines0 !== 10'sd56 || state0 !== C_PLAY)
      $display("FAIL bd_ignored: got %0d/%0d/%b want 200/56/0010", cells0, mines0, state0); else n_pass++;
  endtask

  task automatic test_cursor();
    do_reset();
    start_game(10, 100);
    mv_l = 1; mv_u = 1; tick(); idle_inputs();
    n_checks++; if ({x0, y0} !== 8'h00) $display("FAIL clamp_edge: got (%0d,%0d) want (0,0)", x0, y0); else n_pass++;
    n_checks++; if ({x1, y1} !== 8'hFF) $display("FAIL wrap_edge: got (%0d,%0d) want (15,15)", x1, y1); else n_pass++;
    mv_l = 1; mv_r = 1; tick(); idle_inputs();
    n_checks++; if (x1 !== 4'd15) $display("FAIL lr_cancel: got %0d want 15", x1); else n_pass++;
    mv_r = 1; mv_d = 1; tick(); idle_inputs();
    n_checks++; if ({x0, y0} !== 8'h11) $display("FAIL diag_clamp: got (%0d,%0d) want (1,1)", x0, y0); else n_pass++;
    n_checks++; if ({x1, y1} !== 8'h00) $display("FAIL diag_wrap: got (%0d,%0d) want (0,0)", x1, y1); else n_pass++;
    mv_l = 1; mv_r = 1; mv_d = 1; tick(); idle_inputs();
    n_checks++; if ({x0, y0} !== 8'h12) $display("FAIL lr_cancel_d: got (%0d,%0d) want (1,2)", x0, y0); else n_pass++;
  endtask

  task automatic test_act();
    act = 1; tick(); idle_inputs();
    n_checks++; if ({open0, flag0} !== 2'b10) $display("FAIL open_req: got %b want 10", {open0, flag0}); else n_pass++;
    tick();
    n_checks++; if ({open0, flag0} !== 2'b00) $display("FAIL open_pulse: got %b want 00", {open0, flag0}); else n_pass++;
    act = 1; flag_mode = 1; tick(); idle_inputs();
    n_checks++; if ({open0, flag0} !== 2'b01) $display("FAIL flag_req: got %b want 01", {open0, flag0}); else n_pass++;
  endtask

  task automatic test_win();
    restart = 1; tick(); idle_inputs();
    n_checks++; if (state0 !== C_INIT || brst0 !== 1'b1)
      $display("FAIL restart: got %b/%b want 0001/1", state0, brst0); else n_pass++;
    mv_r = 1; tick(); idle_inputs();
    n_checks++; if (brst0 !== 1'b0 || x0 !== 4'd1)
      $display("FAIL init_idle: got brst=%b x=%0d want brst=0 x=1", brst0, x0); else n_pass++;
    start_game(10, 2);
    cell_opened = 1; tick();
    n_checks++; if (cells0 !== 9'd1 || state0 !== C_PLAY)
      $display("FAIL open_one: got %0d/%b want 1/0010", cells0, state0); else n_pass++;
    tick(); idle_inputs();
    n_checks++; if (cells0 !== 9'd0 || state0 !== C_WIN)
      $display("FAIL win: got %0d/%b want 0/0100", cells0, state0); else n_pass++;
    act = 1; tick(); idle_inputs();
    n_checks++; if (state0 !== C_INIT || brst0 !== 1'b1 || open0 !== 1'b0)
      $display("FAIL win_act: got %b/%b/%b want 0001/1/0", state0, brst0, open0); else n_pass++;
    tick();
    n_checks++; if (brst0 !== 1'b0) $display("FAIL win_brst_pulse: got %b want 0", brst0); else n_pass++;
  endtask

  task automatic test_lose();
    do_reset();
    start_game(5, 50);
    repeat (5) tick();
    cell_opened = 1; opened_is_mine = 1; tick(); idle_inputs();
    n_checks++; if (state0 !== C_LOSE || cells0 !== 9'd50)
      $display("FAIL lose: got %b/%0d want 1000/50", state0, cells0); else n_pass++;
    repeat (10) tick();
    n_checks++; if (time0 !== 10'd1 || cells0 !== 9'd50)
      $display("FAIL lose_frozen: got t=%0d c=%0d want t=1 c=50", time0, cells0); else n_pass++;
    mv_r = 1; tick(); idle_inputs();
    n_checks++; if (x0 !== 4'd1) $display("FAIL lose_move: got %0d want 1", x0); else n_pass++;
    act = 1; tick(); idle_inputs();
    n_checks++; if (state0 !== C_INIT || brst0 !== 1'b1)
      $display("FAIL lose_act: got %b/%b want 0001/1", state0, brst0); else n_pass++;
  endtask

  task automatic test_flags();
    do_reset();
    start_game(1, 100);
    flag_toggled = 1; flag_set = 1; repeat (3) tick(); idle_inputs();
    exp_m = -10'sd2;
    n_checks++; if (mines0 !== exp_m) $display("FAIL flags_neg: got %0d want %0d", mines0, exp_m); else n_pass++;
    flag_toggled = 1; flag_set = 0; tick(); idle_inputs();
    exp_m = -10'sd1;
    n_checks++; if (mines0 !== exp_m) $display("FAIL flags_unset: got %0d want %0d", mines0, exp_m); else n_pass++;
  endtask

  task automatic test_timer();
    do_reset();
    start_game(3, 100);
    repeat (3) tick();
    n_checks++; if (time0 !== 10'd0) $display("FAIL timer_3: got %0d want 0", time0); else n_pass++;
    tick();
    n_checks++; if (time0 !== 10'd1) $display("FAIL timer_4: got %0d want 1", time0); else n_pass++;
    repeat (16) tick();
    n_checks++; if (time0 !== 10'd3) $display("FAIL timer_sat: got %0d want 3", time0); else n_pass++;
    restart = 1; cell_opened = 1; tick(); idle_inputs();
    n_checks++; if (state0 !== C_INIT || cells0 !== 9'd100 || brst0 !== 1'b1 || time0 !== 10'd3)
      $display("FAIL restart_prio: got %b/%0d/%b/%0d want 0001/100/1/3", state0, cells0, brst0, time0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    start_game(3, 1);
    cell_opened = 1; act = 1; tick(); idle_inputs();
    n_checks++; if (state0 !== C_WIN || cells0 !== 9'd0 || open0 !== 1'b0 || brst0 !== 1'b0)
      $display("FAIL win_with_act: got %b/%0d/%b/%b want 0100/0/0/0", state0, cells0, open0, brst0); else n_pass++;
    tick();
    n_checks++; if (state0 !== C_WIN || brst0 !== 1'b0)
      $display("FAIL win_hold: got %b/%b want 0100/0", state0, brst0); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    start_game(7, 70);
    mv_r = 1; tick(); idle_inputs();
    reset = 1;
    #2;
    n_checks++; if (state0 !== C_INIT || x0 !== 4'd0 || cells0 !== '0 || mines0 !== '0)
      $display("FAIL async_reset: got %b/%0d/%0d/%0d want 0001/0/0/0", state0, x0, cells0, mines0); else n_pass++;
    reset = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_board_done();
    test_cursor();
    test_act();
    test_win();
    test_lose();
    test_flags();
    test_timer();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
